// File: rtl/xoro_pkg.sv
// Shared constants, FSM state type and rotate helper for the xoroshiro128+ stream checker.
package xoro_pkg;

   localparam int unsigned ROT_A = 32'd55;
   localparam int unsigned SHL_B = 32'd14;
   localparam int unsigned ROT_C = 32'd36;

   localparam logic [63:0] DEF_SEED0 = 64'h0000_0000_0000_0001;
   localparam logic [63:0] DEF_SEED1 = 64'h0000_0000_0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic logic [63:0] rotl64(input logic [63:0] x, input int unsigned r);
      return (x << r) | (x >> (32'd64 - r));
   endfunction

endpackage

// File: rtl/xoro_step.sv
// Combinational xoroshiro128+ state advance: (s0,s1) -> (s0',s1').
module xoro_step
   import xoro_pkg::*;
(
   input  logic [63:0] s0_i,
   input  logic [63:0] s1_i,
   output logic [63:0] s0_o,
   output logic [63:0] s1_o
);

   logic [63:0] sx_s;

   // One generator step
   always_comb begin
      sx_s = s0_i ^ s1_i;
      s0_o = rotl64(s0_i, ROT_A) ^ sx_s ^ (sx_s << SHL_B);
      s1_o = rotl64(sx_s, ROT_C);
   end

endmodule

// File: rtl/xoro_stream_checker.sv
// Checks an incoming 64-bit word stream against a local xoroshiro128+ reference.
// Optional first-mismatch capture ports are enabled by defining XORO_CHK_CAPTURE_EN.
module xoro_stream_checker
   import xoro_pkg::*;
#(
   parameter logic [63:0] SEED0 = DEF_SEED0,
   parameter logic [63:0] SEED1 = DEF_SEED1,
   parameter int          CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic             in_valid,
   input  logic [63:0]      in_data,
   output logic             in_ready,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] word_count,
   output logic [CNT_W-1:0] err_count
`ifdef XORO_CHK_CAPTURE_EN
   ,
   output logic [CNT_W-1:0] first_err_idx,
   output logic [63:0]      first_err_exp,
   output logic [63:0]      first_err_got
`endif
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   state_e           state_q;
   logic [63:0]      s0_q, s1_q, s0_nx_s, s1_nx_s, exp_s;
   logic [CNT_W-1:0] len_q, word_count_q, err_count_q;
   logic [CNT_W-1:0] word_count_d, err_count_d;
   logic             in_ready_q, busy_q, done_q, pass_q;
   logic             hs_s, mismatch_s;
`ifdef XORO_CHK_CAPTURE_EN
   logic [CNT_W-1:0] first_err_idx_q;
   logic [63:0]      first_err_exp_q, first_err_got_q;
`endif

   xoro_step u_step (
      .s0_i (s0_q),
      .s1_i (s1_q),
      .s0_o (s0_nx_s),
      .s1_o (s1_nx_s)
   );

   // Handshake decode and the counter values a handshake would produce
   always_comb begin
      exp_s        = s0_q + s1_q;
      hs_s         = in_valid && in_ready_q;
      mismatch_s   = (in_data != exp_s);
      word_count_d = word_count_q + CNT_ONE;
      if (mismatch_s && (err_count_q != CNT_MAX)) begin
         err_count_d = err_count_q + CNT_ONE;
      end else begin
         err_count_d = err_count_q;
      end
   end

   // Run-control FSM with reference state, counters and registered status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         s0_q         <= SEED0;
         s1_q         <= SEED1;
         len_q        <= CNT_ZERO;
         word_count_q <= CNT_ZERO;
         err_count_q  <= CNT_ZERO;
         in_ready_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
`ifdef XORO_CHK_CAPTURE_EN
         first_err_idx_q <= CNT_ZERO;
         first_err_exp_q <= 64'h0;
         first_err_got_q <= 64'h0;
`endif
      end else if (start) begin
         // start wins over a same-cycle handshake; that word is dropped
         s0_q         <= SEED0;
         s1_q         <= SEED1;
         len_q        <= len;
         word_count_q <= CNT_ZERO;
         err_count_q  <= CNT_ZERO;
`ifdef XORO_CHK_CAPTURE_EN
         first_err_idx_q <= CNT_ZERO;
         first_err_exp_q <= 64'h0;
         first_err_got_q <= 64'h0;
`endif
         if (len == CNT_ZERO) begin
            state_q    <= ST_DONE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            pass_q     <= 1'b1;
         end else begin
            state_q    <= ST_RUN;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
         end
      end else begin
         case (state_q)
            ST_RUN: begin
               if (hs_s) begin
                  s0_q         <= s0_nx_s;
                  s1_q         <= s1_nx_s;
                  word_count_q <= word_count_d;
                  err_count_q  <= err_count_d;
`ifdef XORO_CHK_CAPTURE_EN
                  // err_count only ever rises, so zero means no earlier mismatch
                  if (mismatch_s && (err_count_q == CNT_ZERO)) begin
                     first_err_idx_q <= word_count_q;
                     first_err_exp_q <= exp_s;
                     first_err_got_q <= in_data;
                  end else begin
                     first_err_idx_q <= first_err_idx_q;
                  end
`endif
                  if (word_count_d == len_q) begin
                     state_q    <= ST_DONE;
                     in_ready_q <= 1'b0;
                     busy_q     <= 1'b0;
                     done_q     <= 1'b1;
                     pass_q     <= (err_count_d == CNT_ZERO);
                  end else begin
                     state_q <= ST_RUN;
                  end
               end else begin
                  state_q <= ST_RUN;
               end
            end
            ST_IDLE: begin
               state_q <= ST_IDLE;
            end
            ST_DONE: begin
               state_q <= ST_DONE;
            end
            default: begin
               state_q    <= ST_IDLE;
               in_ready_q <= 1'b0;
               busy_q     <= 1'b0;
               done_q     <= 1'b0;
               pass_q     <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready   = in_ready_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign word_count = word_count_q;
   assign err_count  = err_count_q;
`ifdef XORO_CHK_CAPTURE_EN
   assign first_err_idx = first_err_idx_q;
   assign first_err_exp = first_err_exp_q;
   assign first_err_got = first_err_got_q;
`endif

endmodule

// File: tb/tb_xoro_stream_checker.sv
// Scoreboard bench for xoro_stream_checker; exercises capture ports when XORO_CHK_CAPTURE_EN is defined.
module tb_xoro_stream_checker;

   localparam int CW = 32;

   typedef struct packed {
      logic [CW-1:0] wc;
      logic [CW-1:0] ec;
   } sb_t;

   logic          clk = 1'b0;
   logic          rst, start, in_valid;
   logic [CW-1:0] len;
   logic [63:0]   in_data;
   logic          in_ready, busy, done, pass;
   logic [CW-1:0] word_count, err_count;
`ifdef XORO_CHK_CAPTURE_EN
   logic [CW-1:0] first_err_idx;
   logic [63:0]   first_err_exp, first_err_got;
`endif

   int  total = 0;
   int  bad   = 0;
   sb_t sb_q[$];

   logic [63:0]   m_s0, m_s1;
   logic [CW-1:0] m_wc, m_ec, m_len;
   logic          m_run, m_done;
   logic [CW-1:0] m_fidx;
   logic [63:0]   m_fexp, m_fgot;

   xoro_stream_checker dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .len        (len),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .word_count (word_count),
      .err_count  (err_count)
`ifdef XORO_CHK_CAPTURE_EN
      ,
      .first_err_idx (first_err_idx),
      .first_err_exp (first_err_exp),
      .first_err_got (first_err_got)
`endif
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic m_seed();
      m_s0 = 64'h1; m_s1 = 64'h0;
      m_wc = '0; m_ec = '0;
      m_fidx = '0; m_fexp = 64'h0; m_fgot = 64'h0;
   endtask

   task automatic m_step();
      logic [63:0] sx;
      sx   = m_s0 ^ m_s1;
      m_s0 = {m_s0[8:0], m_s0[63:9]} ^ sx ^ {sx[49:0], 14'b0};
      m_s1 = {sx[27:0], sx[63:28]};
   endtask

   task automatic check_status(input string tag);
      check_eq({tag, "_in_ready"}, in_ready, m_run);
      check_eq({tag, "_busy"}, busy, m_run);
      check_eq({tag, "_done"}, done, m_done);
      check_eq({tag, "_pass"}, pass, m_done && (m_ec == 0));
   endtask

   task automatic check_capture(input string tag);
`ifdef XORO_CHK_CAPTURE_EN
      check_eq({tag, "_fidx"}, first_err_idx, m_fidx);
      check_eq({tag, "_fexp"}, first_err_exp, m_fexp);
      check_eq({tag, "_fgot"}, first_err_got, m_fgot);
`endif
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      tick();
      rst = 1'b0; start = 1'b0; in_valid = 1'b0;
      m_seed(); m_run = 1'b0; m_done = 1'b0; m_len = '0;
      check_eq({tag, "_wc"}, word_count, 64'h0);
      check_eq({tag, "_ec"}, err_count, 64'h0);
      check_status(tag);
      check_capture(tag);
   endtask

   task automatic do_start(input logic [CW-1:0] l, input logic v, input logic [63:0] d);
      start = 1'b1; len = l; in_valid = v; in_data = d;
      tick();
      start = 1'b0; in_valid = 1'b0;
      m_seed(); m_len = l; m_run = (l != 0); m_done = (l == 0);
      check_eq("start_wc", word_count, 64'h0);
      check_eq("start_ec", err_count, 64'h0);
      check_status("start");
      check_capture("start");
   endtask

   task automatic feed(input logic v, input logic [63:0] d);
      sb_t e;
      logic [63:0] ex;
      in_valid = v; in_data = d;
      if (v && m_run) begin
         ex = m_s0 + m_s1;
         if (d !== ex) begin
            if (m_ec == 0) begin
               m_fidx = m_wc; m_fexp = ex; m_fgot = d;
            end
            m_ec++;
         end
         m_wc++;
         m_step();
         if (m_wc == m_len) begin
            m_run = 1'b0; m_done = 1'b1;
         end
      end
      e.wc = m_wc; e.ec = m_ec;
      sb_q.push_back(e);
      tick();
      in_valid = 1'b0;
      e = sb_q.pop_front();
      check_eq("word_count", word_count, e.wc);
      check_eq("err_count", err_count, e.ec);
      check_eq("in_ready", in_ready, m_run);
   endtask

   initial begin
      int guard;
      logic v;
      rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = 64'h0;
      tick();
      do_reset("reset");

      // words offered while idle are ignored
      feed(1'b1, 64'h1);

      // correct two-word run
      do_start(32'd2, 1'b0, 64'h0);
      feed(1'b1, 64'h1);
      feed(1'b1, 64'h0080_0010_0000_4001);
      check_status("run2_ok");
      check_eq("run2_ok_wc", word_count, 64'd2);

      // second word wrong
      do_start(32'd2, 1'b0, 64'h0);
      feed(1'b1, 64'h1);
      feed(1'b1, 64'h0);
      check_status("run2_bad");
      check_eq("run2_bad_ec", err_count, 64'd1);
      check_capture("run2_bad");
`ifdef XORO_CHK_CAPTURE_EN
      check_eq("run2_bad_fidx_lit", first_err_idx, 64'd1);
      check_eq("run2_bad_fexp_lit", first_err_exp, 64'h0080_0010_0000_4001);
`endif
      // words offered while done are ignored
      feed(1'b1, 64'h1);

      // 1000-word correct stream with random stalls
      do_start(32'd1000, 1'b0, 64'h0);
      guard = 0;
      while (m_run && guard < 5000) begin
         v = ($urandom_range(0, 3) != 0);
         feed(v, v ? (m_s0 + m_s1) : {$urandom, $urandom});
         guard++;
      end
      check_eq("run1000_done", done, 1'b1);
      check_eq("run1000_pass", pass, 1'b1);
      check_eq("run1000_wc", word_count, 64'd1000);

      // restart coinciding with a handshake mid-run
      do_start(32'd5, 1'b0, 64'h0);
      feed(1'b1, m_s0 + m_s1);
      feed(1'b1, m_s0 + m_s1);
      do_start(32'd3, 1'b1, m_s0 + m_s1);
      feed(1'b1, 64'h1);
      check_eq("restart_first_ok", err_count, 64'd0);
      feed(1'b1, m_s0 + m_s1);
      feed(1'b1, m_s0 + m_s1);
      check_status("restart_end");

      // zero-length run
      do_start(32'd0, 1'b0, 64'h0);
      feed(1'b1, 64'h1);
      feed(1'b1, 64'h1);
      check_status("len0");

      // reset in the middle of a run with an error recorded
      do_start(32'd4, 1'b0, 64'h0);
      feed(1'b1, 64'h5);
      in_valid = 1'b1; in_data = 64'h1; start = 1'b1;
      do_reset("mid_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
